// File: rtl/index_match_reader.sv
// Two-pointer merge over two sorted index memories; emits the data pair at every shared index.
// Optional MATCH_STALL_EN adds a match_ready back-pressure input on the match output.
module index_match_reader #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   len1,
    input  logic [AW:0]   len2,
    output logic [AW-1:0] cnt1,
    output logic [AW-1:0] cnt2,
    input  logic [DW-1:0] r1,
    input  logic [DW-1:0] r2,
    output logic [AW-1:0] addr1,
    output logic [AW-1:0] addr2,
    input  logic [DW-1:0] out1,
    input  logic [DW-1:0] out2,
`ifdef MATCH_STALL_EN
    input  logic          match_ready,
`endif
    output logic          match_valid,
    output logic [DW-1:0] match_idx,
    output logic [DW-1:0] match_d1,
    output logic [DW-1:0] match_d2,
    output logic [AW:0]   match_count,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_IDX,
        S_CMP,
        S_RD_DATA,
        S_EMIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [AW:0]   r_p1;
    logic [AW:0]   r_p2;
    logic [AW:0]   r_len1;
    logic [AW:0]   r_len2;
    logic [AW-1:0] r_addr;

    logic [AW:0]   w_p1_inc;
    logic [AW:0]   w_p2_inc;
    logic          w_end_lt;
    logic          w_end_gt;
    logic          w_end_eq;

    assign cnt1     = r_p1[AW-1:0];
    assign cnt2     = r_p2[AW-1:0];
    assign addr1    = r_addr;
    assign addr2    = r_addr;

    assign w_p1_inc = r_p1 + 1'b1;
    assign w_p2_inc = r_p2 + 1'b1;
    // Every step advances at least one pointer, so a pass always terminates.
    assign w_end_lt = (w_p1_inc == r_len1) || (r_p2 == r_len2);
    assign w_end_gt = (r_p1 == r_len1) || (w_p2_inc == r_len2);
    assign w_end_eq = (w_p1_inc == r_len1) || (w_p2_inc == r_len2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_p1        <= '0;
            r_p2        <= '0;
            r_len1      <= '0;
            r_len2      <= '0;
            r_addr      <= '0;
            match_valid <= 1'b0;
            match_idx   <= '0;
            match_d1    <= '0;
            match_d2    <= '0;
            match_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done        <= 1'b0;
            match_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        r_len1      <= len1;
                        r_len2      <= len2;
                        r_p1        <= '0;
                        r_p2        <= '0;
                        r_addr      <= '0;
                        match_count <= '0;
                        match_idx   <= '0;
                        match_d1    <= '0;
                        match_d2    <= '0;
                        busy        <= 1'b1;
                        if (len1 == '0 || len2 == '0)
                            r_state <= S_DONE;
                        else
                            r_state <= S_RD_IDX;
                    end
                end
                S_RD_IDX: r_state <= S_CMP;
                S_CMP: begin
                    if (r1 < r2) begin
                        r_p1    <= w_p1_inc;
                        r_state <= w_end_lt ? S_DONE : S_RD_IDX;
                    end else if (r1 > r2) begin
                        r_p2    <= w_p2_inc;
                        r_state <= w_end_gt ? S_DONE : S_RD_IDX;
                    end else begin
                        match_idx <= r1;
                        r_addr    <= r1[AW-1:0];
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: r_state <= S_EMIT;
                S_EMIT: begin
                    match_d1    <= out1;
                    match_d2    <= out2;
                    match_valid <= 1'b1;
`ifdef MATCH_STALL_EN
                    r_state     <= S_HOLD;
`else
                    match_count <= match_count + 1'b1;
                    r_p1        <= w_p1_inc;
                    r_p2        <= w_p2_inc;
                    r_state     <= w_end_eq ? S_DONE : S_RD_IDX;
`endif
                end
`ifdef MATCH_STALL_EN
                S_HOLD: begin
                    if (match_ready) begin
                        match_count <= match_count + 1'b1;
                        r_p1        <= w_p1_inc;
                        r_p2        <= w_p2_inc;
                        r_state     <= w_end_eq ? S_DONE : S_RD_IDX;
                    end else begin
                        match_valid <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_index_match_reader.sv
// Scoreboard bench for index_match_reader: sync-read memory models plus a merge reference.
// Define MATCH_STALL_EN at compile time to also exercise match_ready back-pressure.
module tb_index_match_reader;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len1 = '0;
    logic [AW:0]   len2 = '0;
    logic [AW-1:0] cnt1, cnt2, addr1, addr2;
    logic [DW-1:0] r1 = '0;
    logic [DW-1:0] r2 = '0;
    logic [DW-1:0] out1 = '0;
    logic [DW-1:0] out2 = '0;
    logic          match_valid, busy, done;
    logic [DW-1:0] match_idx, match_d1, match_d2;
    logic [AW:0]   match_count;
    logic          w_hs;

`ifdef MATCH_STALL_EN
    logic match_ready = 1'b1;
    assign w_hs = match_ready;
`else
    assign w_hs = 1'b1;
`endif

    logic [DW-1:0] idx1_m [16];
    logic [DW-1:0] idx2_m [16];
    logic [DW-1:0] dat1_m [16];
    logic [DW-1:0] dat2_m [16];
    logic [3*DW-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r1   <= idx1_m[cnt1];
        r2   <= idx2_m[cnt2];
        out1 <= dat1_m[addr1];
        out2 <= dat2_m[addr2];
    end

    index_match_reader #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .len1(len1), .len2(len2),
        .cnt1(cnt1), .cnt2(cnt2), .r1(r1), .r2(r2),
        .addr1(addr1), .addr2(addr2), .out1(out1), .out2(out2),
`ifdef MATCH_STALL_EN
        .match_ready(match_ready),
`endif
        .match_valid(match_valid), .match_idx(match_idx),
        .match_d1(match_d1), .match_d2(match_d2),
        .match_count(match_count), .busy(busy), .done(done)
    );

    always @(negedge clk) begin
        logic [3*DW-1:0] e;
        if (reset && match_valid && w_hs) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL match_extra: got %h/%h/%h, required no strobe",
                         match_idx, match_d1, match_d2);
            end else begin
                e = exp_q.pop_front();
                if ({match_idx, match_d1, match_d2} !== e) begin
                    errors++;
                    $display("FAIL match_data: got %h/%h/%h, required %h/%h/%h",
                             match_idx, match_d1, match_d2,
                             e[23:16], e[15:8], e[7:0]);
                end
            end
        end
    end

    function automatic int model_push(int l1, int l2);
        int i = 0;
        int j = 0;
        int n = 0;
        logic [3:0] a;
        while (i < l1 && j < l2) begin
            if (idx1_m[i] < idx2_m[j]) i++;
            else if (idx1_m[i] > idx2_m[j]) j++;
            else begin
                a = idx1_m[i][3:0];
                exp_q.push_back({idx1_m[i], dat1_m[a], dat2_m[a]});
                n++; i++; j++;
            end
        end
        return n;
    endfunction

    task automatic fill_default();
        for (int k = 0; k < 16; k++) begin
            idx1_m[k] = 8'hFF;
            idx2_m[k] = 8'hFF;
            dat1_m[k] = 8'hA0 + 8'(k);
            dat2_m[k] = 8'hB0 + 8'(k);
        end
    endtask

    task automatic load_basic();
        fill_default();
        idx1_m[0] = 1; idx1_m[1] = 3; idx1_m[2] = 5; idx1_m[3] = 7;
        idx2_m[0] = 3; idx2_m[1] = 4; idx2_m[2] = 7; idx2_m[3] = 9;
    endtask

    task automatic pulse_start(int a, int b);
        @(negedge clk);
        len1  = 5'(a);
        len2  = 5'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({cnt1, cnt2, addr1, addr2, match_valid, match_idx, match_d1,
             match_d2, match_count, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero (busy=%b cnt=%0d idx=%h), required all 0",
                     busy, match_count, match_idx);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic(string name, bit double_start);
        bit ok;
        int n;
        load_basic();
        n = model_push(4, 4);
        pulse_start(4, 4);
        if (double_start) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(200, ok);
        checks++;
        if (!ok || match_count !== 5'(n) || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: done=%b count=%0d busy=%b left=%0d, required 1/%0d/0/0",
                     name, ok, match_count, busy, exp_q.size(), n);
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL %s_model: got %0d matches, required 2", name, n);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || match_count !== 5'd2 || match_idx !== 8'h07) begin
            errors++;
            $display("FAIL %s_hold: done=%b count=%0d idx=%h, required 0/2/07",
                     name, done, match_count, match_idx);
        end
    endtask

    task automatic test_disjoint();
        bit ok;
        fill_default();
        idx1_m[0] = 2; idx1_m[1] = 4;
        idx2_m[0] = 1; idx2_m[1] = 3; idx2_m[2] = 5;
        pulse_start(2, 3);
        wait_done(100, ok);
        checks++;
        if (!ok || match_count !== 5'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL disjoint: done=%b count=%0d, required 1/0", ok, match_count);
        end
    endtask

    task automatic test_empty();
        fill_default();
        @(negedge clk);
        len1  = 5'd0;
        len2  = 5'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL empty_c1: busy=%b done=%b, required 1/0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || match_count !== 5'd0 || cnt1 !== 4'd0) begin
            errors++;
            $display("FAIL empty_c2: done=%b busy=%b count=%0d cnt1=%0d, required 1/0/0/0",
                     done, busy, match_count, cnt1);
        end
    endtask

    task automatic test_full();
        bit ok;
        int n;
        fill_default();
        for (int k = 0; k < 16; k++) begin
            idx1_m[k] = 8'(k);
            idx2_m[k] = 8'(k);
        end
        n = model_push(16, 16);
        pulse_start(16, 16);
        wait_done(300, ok);
        checks++;
        if (!ok || match_count !== 5'h10 || n != 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full: done=%b count=%h left=%0d, required 1/10/0",
                     ok, match_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        load_basic();
        void'(model_push(4, 4));
        pulse_start(4, 4);
        for (int k = 0; k < 100; k++) begin
            if (addr1 == 4'd3) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (!hit || {match_valid, match_idx, match_d1, match_d2, match_count,
                     busy, done, cnt1, cnt2, addr1} !== '0) begin
            errors++;
            $display("FAIL reset_mid: hit=%b busy=%b addr=%h cnt=%0d, required 1/0/0/0",
                     hit, busy, addr1, match_count);
        end
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: done=%b busy=%b, required 0/0", done, busy);
        end
        reset = 1'b1;
        test_basic("after_reset", 1'b0);
    endtask

    task automatic test_random();
        bit ok;
        int n, l1, l2, v;
        for (int it = 0; it < 6; it++) begin
            fill_default();
            for (int k = 0; k < 16; k++) begin
                dat1_m[k] = 8'($urandom);
                dat2_m[k] = 8'($urandom);
            end
            v = $urandom_range(0, 2);
            for (int k = 0; k < 16; k++) begin
                idx1_m[k] = 8'(v);
                v += $urandom_range(0, 3);
            end
            v = $urandom_range(0, 2);
            for (int k = 0; k < 16; k++) begin
                idx2_m[k] = 8'(v);
                v += $urandom_range(0, 3);
            end
            l1 = $urandom_range(1, 16);
            l2 = $urandom_range(1, 16);
            n = model_push(l1, l2);
            pulse_start(l1, l2);
            wait_done(400, ok);
            checks++;
            if (!ok || match_count !== 5'(n) || exp_q.size() != 0) begin
                errors++;
                $display("FAIL random_%0d: done=%b count=%0d left=%0d, required 1/%0d/0",
                         it, ok, match_count, exp_q.size(), n);
            end
        end
    endtask

`ifdef MATCH_STALL_EN
    task automatic test_stall();
        bit ok;
        bit seen = 1'b0;
        load_basic();
        void'(model_push(4, 4));
        @(negedge clk);
        match_ready = 1'b0;
        pulse_start(4, 4);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (match_valid) begin
                seen = 1'b1;
                break;
            end
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (!seen || match_valid !== 1'b1 || match_idx !== 8'h03 ||
                match_d1 !== 8'hA3 || match_d2 !== 8'hB3 || match_count !== 5'd0) begin
                errors++;
                $display("FAIL stall_hold_%0d: v=%b %h/%h/%h cnt=%0d, required 1 03/A3/B3 0",
                         k, match_valid, match_idx, match_d1, match_d2, match_count);
            end
            if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        #2 match_ready = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (match_count !== 5'd1) begin
            errors++;
            $display("FAIL stall_count: got %0d, required 1", match_count);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || match_count !== 5'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_final: done=%b count=%0d, required 1/2", ok, match_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic("basic", 1'b0);
        test_disjoint();
        test_empty();
        test_full();
        test_basic("busy_start", 1'b1);
        test_reset_mid();
        test_random();
`ifdef MATCH_STALL_EN
        test_stall();
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
